// File: rtl/risc_pkg.sv
// Shared constants for the single-step 8-bit RISC board wrapper:
// widths, opcode values, instruction field positions and the program ROM.
package risc_pkg;

    localparam int DATA_W  = 8;
    localparam int PC_W    = 4;
    localparam int INSTR_W = 16;
    localparam int NREGS   = 4;

    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 10;
    localparam int RS_LSB  = 8;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_BEQZ = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Fixed demo program: R0 += R1 for R1 = 3..1, then halt.
    function automatic logic [INSTR_W-1:0] rom_word(input logic [PC_W-1:0] addr);
        logic [INSTR_W-1:0] word;
        case (addr)
            4'd0:    word = 16'h1005;
            4'd1:    word = 16'h1403;
            4'd2:    word = 16'h2100;
            4'd3:    word = 16'h84FF;
            4'd4:    word = 16'hA406;
            4'd5:    word = 16'h9002;
            4'd6:    word = 16'hF000;
            default: word = 16'h0000;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/risc_top_hex7seg.sv
// Hex digit to active-low 7-segment glyph, segment order {g,f,e,d,c,b,a}.
module hex7seg (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Glyph lookup for 0-F
    always_comb begin
        case (digit)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/risc_top.sv
// Single-cycle 8-bit RISC core stepped by KEY[0], with state shown on LEDR
// and six hex displays. CLOCK_50 is deliberately ignored.
module risc_top
    import risc_pkg::*;
(
    input  logic [3:0] KEY,
    input  logic       CLOCK_50,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    logic              clk;
    logic              rst;
    logic [1:0]        sel_s;
    logic              unused_clock50_s;

    // Power-up values equal reset values so stepping without a reset is defined.
    logic [PC_W-1:0]   pc_r                  = 4'd0;
    logic [DATA_W-1:0] regs_r [0:NREGS-1]    = '{default: 8'h00};
    logic              halted_r              = 1'b0;

    logic [INSTR_W-1:0] instr_s;
    logic [3:0]         op_s;
    logic [1:0]         rd_s;
    logic [1:0]         rs_s;
    logic [DATA_W-1:0]  imm_s;
    logic [DATA_W-1:0]  rd_val_s;
    logic [DATA_W-1:0]  rs_val_s;
    logic [DATA_W-1:0]  sel_val_s;
    logic               wr_en_s;
    logic [DATA_W-1:0]  wr_data_s;
    logic [PC_W-1:0]    pc_next_s;
    logic               halt_next_s;

    assign clk              = KEY[0];
    assign rst              = KEY[1];
    assign sel_s            = KEY[3:2];
    assign unused_clock50_s = CLOCK_50;

    assign instr_s   = rom_word(pc_r);
    assign op_s      = instr_s[OP_LSB +: 4];
    assign rd_s      = instr_s[RD_LSB +: 2];
    assign rs_s      = instr_s[RS_LSB +: 2];
    assign imm_s     = instr_s[IMM_LSB +: DATA_W];
    assign rd_val_s  = regs_r[rd_s];
    assign rs_val_s  = regs_r[rs_s];
    assign sel_val_s = regs_r[sel_s];

    // Decode and ALU: result, write enable and next PC for the current instruction
    always_comb begin
        wr_en_s     = 1'b0;
        wr_data_s   = 8'h00;
        pc_next_s   = pc_r + 4'd1;
        halt_next_s = 1'b0;
        case (op_s)
            OP_LDI:  begin wr_en_s = 1'b1; wr_data_s = imm_s;               end
            OP_ADD:  begin wr_en_s = 1'b1; wr_data_s = rd_val_s + rs_val_s; end
            OP_SUB:  begin wr_en_s = 1'b1; wr_data_s = rd_val_s - rs_val_s; end
            OP_AND:  begin wr_en_s = 1'b1; wr_data_s = rd_val_s & rs_val_s; end
            OP_OR:   begin wr_en_s = 1'b1; wr_data_s = rd_val_s | rs_val_s; end
            OP_XOR:  begin wr_en_s = 1'b1; wr_data_s = rd_val_s ^ rs_val_s; end
            OP_MOV:  begin wr_en_s = 1'b1; wr_data_s = rs_val_s;            end
            OP_ADDI: begin wr_en_s = 1'b1; wr_data_s = rd_val_s + imm_s;    end
            OP_JMP:  pc_next_s = imm_s[PC_W-1:0];
            OP_BEQZ: begin
                if (rd_val_s == 8'h00) begin
                    pc_next_s = imm_s[PC_W-1:0];
                end else begin
                    pc_next_s = pc_r + 4'd1;
                end
            end
            OP_HALT: begin pc_next_s = pc_r; halt_next_s = 1'b1; end
            default: pc_next_s = pc_r + 4'd1;
        endcase
    end

    // Architectural state update; reset wins, halted freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r     <= 4'd0;
            halted_r <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else if (!halted_r) begin
            pc_r     <= pc_next_s;
            halted_r <= halt_next_s;
            if (wr_en_s) begin
                regs_r[rd_s] <= wr_data_s;
            end
        end
    end

    assign LEDR = {halted_r, (sel_val_s == 8'h00), op_s, pc_r};

    hex7seg u_hex0 (.digit(sel_val_s[3:0]), .seg(HEX0));
    hex7seg u_hex1 (.digit(sel_val_s[7:4]), .seg(HEX1));
    hex7seg u_hex2 (.digit(regs_r[0][3:0]), .seg(HEX2));
    hex7seg u_hex3 (.digit(regs_r[1][3:0]), .seg(HEX3));
    hex7seg u_hex4 (.digit(pc_r),           .seg(HEX4));
    hex7seg u_hex5 (.digit(op_s),           .seg(HEX5));

endmodule

// File: tb/tb_risc_top.sv
// Bench for risc_top: directed walk through the demo program, then random
// resets/selects checked against an instruction-level model of the core.
module tb_risc_top;

    logic       key_clk  = 1'b0;
    logic       key_rst  = 1'b0;
    logic [1:0] key_sel  = 2'b00;
    logic       clock_50 = 1'b0;
    logic [9:0] ledr;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_pc;
    int m_r [4];
    int m_halted;

    int rom [16] = '{32'h1005, 32'h1403, 32'h2100, 32'h84FF, 32'hA406, 32'h9002, 32'hF000,
                     0, 0, 0, 0, 0, 0, 0, 0, 0};
    int glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    risc_top dut (
        .KEY      ({key_sel, key_rst, key_clk}),
        .CLOCK_50 (clock_50),
        .LEDR     (ledr),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX2     (hex2),
        .HEX3     (hex3),
        .HEX4     (hex4),
        .HEX5     (hex5)
    );

    always #3 clock_50 = ~clock_50;

    task automatic check_value(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_halted = 0;
        for (int i = 0; i < 4; i++) m_r[i] = 0;
    endtask

    task automatic model_step(input bit rst_v);
        int ins, op, rd, rs, imm, npc;
        if (rst_v) begin
            model_reset();
        end else if (m_halted == 0) begin
            ins = rom[m_pc];
            op  = ins / 4096;
            rd  = (ins / 1024) % 4;
            rs  = (ins / 256) % 4;
            imm = ins % 256;
            npc = (m_pc + 1) % 16;
            case (op)
                1:  m_r[rd] = imm;
                2:  m_r[rd] = (m_r[rd] + m_r[rs]) % 256;
                3:  m_r[rd] = (m_r[rd] - m_r[rs] + 256) % 256;
                4:  m_r[rd] = m_r[rd] & m_r[rs];
                5:  m_r[rd] = m_r[rd] | m_r[rs];
                6:  m_r[rd] = m_r[rd] ^ m_r[rs];
                7:  m_r[rd] = m_r[rs];
                8:  m_r[rd] = (m_r[rd] + imm) % 256;
                9:  npc = imm % 16;
                10: if (m_r[rd] == 0) npc = imm % 16;
                15: begin npc = m_pc; m_halted = 1; end
                default: ;
            endcase
            m_pc = npc;
        end
    endtask

    task automatic compare_all(input string tag);
        int sel_val, op, exp_led;
        sel_val = m_r[key_sel];
        op      = rom[m_pc] / 4096;
        exp_led = m_halted * 512 + (sel_val == 0 ? 256 : 0) + op * 16 + m_pc;
        check_value({tag, ".ledr"}, int'(ledr), exp_led);
        check_value({tag, ".hex0"}, int'(hex0), glyph[sel_val % 16]);
        check_value({tag, ".hex1"}, int'(hex1), glyph[sel_val / 16]);
        check_value({tag, ".hex2"}, int'(hex2), glyph[m_r[0] % 16]);
        check_value({tag, ".hex3"}, int'(hex3), glyph[m_r[1] % 16]);
        check_value({tag, ".hex4"}, int'(hex4), glyph[m_pc]);
        check_value({tag, ".hex5"}, int'(hex5), glyph[op]);
    endtask

    task automatic tick(input bit rst_v, input logic [1:0] sel_v);
        key_rst = rst_v;
        key_sel = sel_v;
        #2;
        key_clk = 1'b1;
        model_step(rst_v);
        #3;
        key_clk = 1'b0;
        #5;
    endtask

    initial begin
        int n;
        model_reset();
        #4;
        compare_all("powerup");

        tick(1'b0, 2'b00);
        check_value("step1.pc", int'(ledr[3:0]), 1);
        check_value("step1.hex4", int'(hex4), 7'h79);
        check_value("step1.hex2", int'(hex2), 7'h12);
        compare_all("step1");

        for (int i = 2; i <= 10; i++) tick(1'b0, 2'b00);
        check_value("step10.pc", int'(ledr[3:0]), 2);
        check_value("step10.halt", int'(ledr[9]), 0);
        check_value("step10.hex1", int'(hex1), 7'h40);
        check_value("step10.hex0", int'(hex0), 7'h08);
        compare_all("step10");
        key_sel = 2'b01;
        #2;
        check_value("sel1.hex0", int'(hex0), 7'h79);
        check_value("sel1.hex1", int'(hex1), 7'h40);
        key_sel = 2'b10;
        #2;
        check_value("sel2.hex0", int'(hex0), 7'h40);
        check_value("sel2.zero", int'(ledr[8]), 1);
        compare_all("sel2");

        for (int i = 11; i <= 14; i++) tick(1'b0, 2'b00);
        check_value("step14.pc", int'(ledr[3:0]), 6);
        check_value("step14.halt", int'(ledr[9]), 1);
        check_value("step14.hex2", int'(hex2), 7'h03);
        compare_all("step14");
        for (int i = 0; i < 5; i++) tick(1'b0, 2'b00);
        compare_all("halted");

        // Reset mid-program, then restart
        tick(1'b1, 2'b00);
        for (int i = 0; i < 7; i++) tick(1'b0, 2'b00);
        tick(1'b1, 2'b00);
        check_value("rst.pc", int'(ledr[3:0]), 0);
        compare_all("rst");
        tick(1'b0, 2'b00);
        check_value("rst.r0", int'(hex2), 7'h12);

        // Free-running CLOCK_50 with KEY[0] static must not change state
        #200;
        compare_all("clk50");

        // Random resets and display selects against the model
        for (int i = 0; i < 300; i++) begin
            n = $urandom_range(0, 15);
            tick(n == 0, 2'($urandom_range(0, 3)));
            compare_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
